rx_os_detect_multi: RTL and testbench
=====================================

Name: rx_os_detect_multi

Overview:
- Parametrised multi-lane receive ordered-set detector for the PCIe logical physical layer.
- Sits after the 8b/10b decoder and descrambler and feeds LTSSM and link-training logic.
- Each lane independently parses TS1, TS2, SKP, EIOS and FTS ordered sets and captures TS fields.
- Counts consecutive identical TSs against a programmable threshold. Flags malformed sets.

Parameters:
- NUM_LANES, 4, number of independent lanes (1..16)
- TS_MATCH_COUNT, 8, consecutive identical TSs required to assert TsMatched
- CNT_WIDTH, 4, width of the per-lane consecutive TS counter (saturating)

Ports:
- Clk  input  1  symbol clock
- notReset  input  1  asynchronous active-low reset
- Synced  input  NUM_LANES  per-lane symbol lock
- RxValid  input  NUM_LANES  per-lane symbol valid; a symbol is consumed only when high
- RxCtrl  input  NUM_LANES  per-lane K-symbol flag
- RxByte  input  8*NUM_LANES  per-lane decoded byte; TS bytes are unscrambled
- ClrCounts  input  1  synchronous clear of all consecutive counters
- TsValid  output  NUM_LANES  one-cycle pulse: a complete, well-formed TS was received
- TsType  output  2*NUM_LANES  per lane {TS2,TS1}
- TsLinkNum  output  9*NUM_LANES  per lane {isPAD, byte}, from symbol 1
- TsLaneNum  output  9*NUM_LANES  per lane {isPAD, byte}, from symbol 2
- TsNFts  output  8*NUM_LANES  symbol 3
- TsRate  output  8*NUM_LANES  symbol 4
- TsTrnCtl  output  8*NUM_LANES  symbol 5
- TsConsec  output  CNT_WIDTH*NUM_LANES  consecutive identical TS count
- TsMatched  output  NUM_LANES  TsConsec >= TS_MATCH_COUNT
- SkpDet  output  NUM_LANES  pulse: SKP ordered set ended
- SkpLen  output  3*NUM_LANES  number of SKP symbols (1..5)
- EiosDet  output  NUM_LANES  pulse: COM + 3 IDL received
- FtsDet  output  NUM_LANES  pulse: COM + 3 FTS received
- OsError  output  NUM_LANES  pulse: malformed ordered set

Behaviour:
- Codes (K unless noted): COM 0xBC, PAD 0xF7, SKP 0x1C, IDL 0x7C, FTS 0x3C. TS1_ID 0x4A (D), TS2_ID 0x45 (D).
- Reset: all outputs and counters 0; every lane FSM in HUNT.
- Per-lane FSM states: HUNT, POS1, TS, SKP, EIOS, FTS. Transitions happen only on cycles where RxValid is high; otherwise the lane holds.
- HUNT: COM -> POS1. Any other symbol is ignored.
- POS1, on symbol 1:
  - D byte or PAD -> TS (capture link number, position = 2).
  - SKP -> SKP (count = 1).
  - IDL -> EIOS (count = 1).
  - FTS -> FTS (count = 1).
  - COM -> stay in POS1, no error.
  - Other K -> OsError, HUNT.
- TS:
  - Symbol 2 may be PAD or D. Symbols 3-5 must be D.
  - Symbols 6-15 must be D and equal to TS1_ID or TS2_ID. Symbol 6 fixes the type; symbols 7-15 must match it.
  - Any violation -> OsError, HUNT. A COM mid-TS -> OsError, POS1.
  - After symbol 15 is accepted: TsValid pulses next cycle; fields and TsType update in that same cycle and hold until the next TsValid.
- Consecutive count:
  - On TsValid, if {type, link, lane, nfts, rate, ctrl} equals the previously captured set, TsConsec increments, saturating at 2^CNT_WIDTH-1. Otherwise TsConsec loads 1.
  - An OsError on a lane does not alter its count.
- SKP:
  - Each further SKP increments the count.
  - The first non-SKP symbol ends the set: SkpDet pulses with SkpLen = count. If that symbol is COM -> POS1, else HUNT.
  - A 6th SKP -> OsError, HUNT, no SkpDet.
- EIOS/FTS:
  - Third IDL/FTS after COM -> EiosDet/FtsDet pulse next cycle, then HUNT.
  - A mismatched symbol -> OsError, HUNT; a mismatched COM instead goes to POS1.
- Synced low on a lane: FSM -> HUNT, TsConsec -> 0, no pulses that cycle. Already-captured fields hold.
- ClrCounts: all TsConsec -> 0 next cycle. If it coincides with TsValid, clear takes priority and the count becomes 0.
- All detection pulses have 1-cycle latency after the final accepted symbol. Lanes are fully independent; there is no deskew.
- Asserting notReset mid-set aborts it immediately with no pulse.

Test Plan:
- Lane 0: 8 identical TS1 (link 0x01, lane 0x00, nfts 0x20, rate 0x02, ctl 0x00) -> 8 TsValid pulses, TsConsec 1..8, TsMatched high after the 8th.
- Lane 1: TS2 with PAD link/lane, then a TS2 differing in nfts -> TsLinkNum/TsLaneNum = 0x1F7; TsConsec returns to 1.
- COM followed by 3 SKP, then COM + TS1 -> SkpDet with SkpLen = 3, then a valid TS1. COM followed by 6 SKP -> OsError, no SkpDet.
- COM IDL IDL IDL -> EiosDet. COM FTS FTS FTS -> FtsDet. COM IDL FTS -> OsError.
- TS1 with symbol 10 = 0x45 -> OsError, no TsValid, TsConsec unchanged. COM at symbol 8 -> OsError, and the following TS parses correctly.
- RxValid gaps inside a TS -> same result as the gap-free case. Synced dropped mid-TS -> no TsValid, TsConsec = 0. ClrCounts together with TsValid -> TsConsec = 0.

Source files
------------

// File: rtl/rx_os_detect_multi.sv
// rtl/rx_os_detect_multi.sv - multi-lane PCIe receive ordered-set detector (TS1/TS2/SKP/EIOS/FTS)
module rx_os_detect_multi #(
  parameter int NUM_LANES      = 4,
  parameter int TS_MATCH_COUNT = 8,
  parameter int CNT_WIDTH      = 4
) (
  input  logic                           Clk,
  input  logic                           notReset,
  input  logic [NUM_LANES-1:0]           Synced,
  input  logic [NUM_LANES-1:0]           RxValid,
  input  logic [NUM_LANES-1:0]           RxCtrl,
  input  logic [8*NUM_LANES-1:0]         RxByte,
  input  logic                           ClrCounts,
  output logic [NUM_LANES-1:0]           TsValid,
  output logic [2*NUM_LANES-1:0]         TsType,
  output logic [9*NUM_LANES-1:0]         TsLinkNum,
  output logic [9*NUM_LANES-1:0]         TsLaneNum,
  output logic [8*NUM_LANES-1:0]         TsNFts,
  output logic [8*NUM_LANES-1:0]         TsRate,
  output logic [8*NUM_LANES-1:0]         TsTrnCtl,
  output logic [CNT_WIDTH*NUM_LANES-1:0] TsConsec,
  output logic [NUM_LANES-1:0]           TsMatched,
  output logic [NUM_LANES-1:0]           SkpDet,
  output logic [3*NUM_LANES-1:0]         SkpLen,
  output logic [NUM_LANES-1:0]           EiosDet,
  output logic [NUM_LANES-1:0]           FtsDet,
  output logic [NUM_LANES-1:0]           OsError
);
  localparam logic [7:0]  COM = 8'hBC, PAD = 8'hF7, SKP = 8'h1C, IDL = 8'h7C, FTS = 8'h3C;
  localparam logic [7:0]  TS1_ID = 8'h4A, TS2_ID = 8'h45;
  localparam logic [31:0] MATCH_U = TS_MATCH_COUNT;

  typedef enum logic [2:0] {sHunt, sPos1, sTs, sSkp, sEios, sFts} state_t;

  for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
    state_t state, stateNext;
    logic [3:0] pos, posNext;
    logic [2:0] cnt, cntNext;
    logic       k, isCom, isPad, isSkp, isIdl, isFts, symOk;
    logic [7:0] b;
    logic       capLink, capLane, capNfts, capRate, capCtl, capType;
    logic       tsDone, skpDone, eiosDone, ftsDone, osErr;
    logic [8:0] linkTmp, laneTmp;
    logic [7:0] nftsTmp, rateTmp, ctlTmp;
    logic       isTs2;
    logic       tsValidQ, skpDetQ, eiosDetQ, ftsDetQ, osErrQ;
    logic [1:0] typeQ;
    logic [8:0] linkQ, laneQ;
    logic [7:0] nftsQ, rateQ, ctlQ;
    logic [2:0] skpLenQ;
    logic [CNT_WIDTH-1:0] consecQ;
    logic       sameSet;

    assign k     = RxCtrl[i];
    assign b     = RxByte[8*i +: 8];
    assign isCom = k && (b == COM);
    assign isPad = k && (b == PAD);
    assign isSkp = k && (b == SKP);
    assign isIdl = k && (b == IDL);
    assign isFts = k && (b == FTS);
    assign sameSet = ({isTs2, ~isTs2, linkTmp, laneTmp, nftsTmp, rateTmp, ctlTmp} ==
                      {typeQ, linkQ, laneQ, nftsQ, rateQ, ctlQ});

    always_comb begin
      stateNext = state;
      posNext   = pos;
      cntNext   = cnt;
      capLink = 1'b0; capLane = 1'b0; capNfts = 1'b0;
      capRate = 1'b0; capCtl  = 1'b0; capType = 1'b0;
      tsDone = 1'b0; skpDone = 1'b0; eiosDone = 1'b0; ftsDone = 1'b0; osErr = 1'b0;
      symOk = 1'b0;
      if (pos == 4'd2)      symOk = !k || isPad;
      else if (pos <= 4'd5) symOk = !k;
      else if (pos == 4'd6) symOk = !k && (b == TS1_ID || b == TS2_ID);
      else                  symOk = !k && (b == (isTs2 ? TS2_ID : TS1_ID));

      if (!Synced[i]) begin
        stateNext = sHunt;
      end else if (RxValid[i]) begin
        case (state)
          sHunt: if (isCom) stateNext = sPos1;
          sPos1: begin
            if (!k || isPad) begin
              stateNext = sTs; posNext = 4'd2; capLink = 1'b1;
            end else if (isSkp) begin
              stateNext = sSkp; cntNext = 3'd1;
            end else if (isIdl) begin
              stateNext = sEios; cntNext = 3'd1;
            end else if (isFts) begin
              stateNext = sFts; cntNext = 3'd1;
            end else if (!isCom) begin
              osErr = 1'b1; stateNext = sHunt;
            end
          end
          sTs: begin
            if (isCom) begin
              osErr = 1'b1; stateNext = sPos1;
            end else if (!symOk) begin
              osErr = 1'b1; stateNext = sHunt;
            end else begin
              posNext = pos + 4'd1;
              capLane = (pos == 4'd2);
              capNfts = (pos == 4'd3);
              capRate = (pos == 4'd4);
              capCtl  = (pos == 4'd5);
              capType = (pos == 4'd6);
              if (pos == 4'd15) begin
                tsDone = 1'b1; stateNext = sHunt;
              end
            end
          end
          sSkp: begin
            if (isSkp) begin
              if (cnt == 3'd5) begin
                osErr = 1'b1; stateNext = sHunt;
              end else begin
                cntNext = cnt + 3'd1;
              end
            end else begin
              skpDone = 1'b1; stateNext = isCom ? sPos1 : sHunt;
            end
          end
          sEios, sFts: begin
            if ((state == sEios) ? isIdl : isFts) begin
              if (cnt == 3'd2) begin
                eiosDone = (state == sEios); ftsDone = (state == sFts); stateNext = sHunt;
              end else begin
                cntNext = cnt + 3'd1;
              end
            end else begin
              osErr = 1'b1; stateNext = isCom ? sPos1 : sHunt;
            end
          end
          default: stateNext = sHunt;
        endcase
      end
    end

    always_ff @(posedge Clk or negedge notReset) begin
      if (!notReset) begin
        state <= sHunt; pos <= '0; cnt <= '0;
        linkTmp <= '0; laneTmp <= '0; nftsTmp <= '0; rateTmp <= '0; ctlTmp <= '0; isTs2 <= 1'b0;
        tsValidQ <= 1'b0; skpDetQ <= 1'b0; eiosDetQ <= 1'b0; ftsDetQ <= 1'b0; osErrQ <= 1'b0;
        typeQ <= '0; linkQ <= '0; laneQ <= '0; nftsQ <= '0; rateQ <= '0; ctlQ <= '0;
        skpLenQ <= '0; consecQ <= '0;
      end else begin
        state <= stateNext; pos <= posNext; cnt <= cntNext;
        if (capLink) linkTmp <= {isPad, b};
        if (capLane) laneTmp <= {isPad, b};
        if (capNfts) nftsTmp <= b;
        if (capRate) rateTmp <= b;
        if (capCtl)  ctlTmp  <= b;
        if (capType) isTs2   <= (b == TS2_ID);
        tsValidQ <= tsDone; skpDetQ <= skpDone; eiosDetQ <= eiosDone;
        ftsDetQ  <= ftsDone; osErrQ <= osErr;
        if (skpDone) skpLenQ <= cnt;
        if (tsDone) begin
          typeQ <= {isTs2, ~isTs2}; linkQ <= linkTmp; laneQ <= laneTmp;
          nftsQ <= nftsTmp; rateQ <= rateTmp; ctlQ <= ctlTmp;
        end
        // A clear wins over a TS finishing on the same edge; the fields still update.
        if (ClrCounts || !Synced[i])
          consecQ <= '0;
        else if (tsDone)
          consecQ <= !sameSet ? CNT_WIDTH'(1) : ((&consecQ) ? consecQ : consecQ + 1'b1);
      end
    end

    assign TsValid[i]                   = tsValidQ;
    assign TsType[2*i +: 2]             = typeQ;
    assign TsLinkNum[9*i +: 9]          = linkQ;
    assign TsLaneNum[9*i +: 9]          = laneQ;
    assign TsNFts[8*i +: 8]             = nftsQ;
    assign TsRate[8*i +: 8]             = rateQ;
    assign TsTrnCtl[8*i +: 8]           = ctlQ;
    assign TsConsec[CNT_WIDTH*i +: CNT_WIDTH] = consecQ;
    assign TsMatched[i]                 = (32'(consecQ) >= MATCH_U);
    assign SkpDet[i]                    = skpDetQ;
    assign SkpLen[3*i +: 3]             = skpLenQ;
    assign EiosDet[i]                   = eiosDetQ;
    assign FtsDet[i]                    = ftsDetQ;
    assign OsError[i]                   = osErrQ;
  end
endmodule

// File: tb/tb_rx_os_detect_multi.sv
// tb/tb_rx_os_detect_multi.sv - self-checking bench for rx_os_detect_multi
module tb_rx_os_detect_multi;
  localparam int NL = 4;
  localparam int CMAX = 15;
  localparam logic [8:0] COMS = 9'h1BC, PADS = 9'h1F7, SKPS = 9'h11C, IDLS = 9'h17C, FTSS = 9'h13C;
  localparam int K_PEND = 0, K_NONE = 1, K_TS = 2, K_SKP = 3, K_EIOS = 4, K_FTS = 5, K_ERR = 6;

  logic Clk, notReset, ClrCounts;
  logic [NL-1:0] Synced, RxValid, RxCtrl;
  logic [8*NL-1:0] RxByte;
  logic [NL-1:0] TsValid, TsMatched, SkpDet, EiosDet, FtsDet, OsError;
  logic [2*NL-1:0] TsType;
  logic [9*NL-1:0] TsLinkNum, TsLaneNum;
  logic [8*NL-1:0] TsNFts, TsRate, TsTrnCtl;
  logic [4*NL-1:0] TsConsec;
  logic [3*NL-1:0] SkpLen;

  rx_os_detect_multi #(.NUM_LANES(NL), .TS_MATCH_COUNT(8), .CNT_WIDTH(4)) dut (
    .Clk(Clk), .notReset(notReset), .Synced(Synced), .RxValid(RxValid), .RxCtrl(RxCtrl),
    .RxByte(RxByte), .ClrCounts(ClrCounts), .TsValid(TsValid), .TsType(TsType),
    .TsLinkNum(TsLinkNum), .TsLaneNum(TsLaneNum), .TsNFts(TsNFts), .TsRate(TsRate),
    .TsTrnCtl(TsTrnCtl), .TsConsec(TsConsec), .TsMatched(TsMatched), .SkpDet(SkpDet),
    .SkpLen(SkpLen), .EiosDet(EiosDet), .FtsDet(FtsDet), .OsError(OsError));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int nChk = 0, nPass = 0;
  bit running = 1'b1;
  int tsSeen[NL], skpSeen[NL], eiosSeen[NL], ftsSeen[NL], errSeen[NL], lastSkpLen[NL];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: each lane buffers the symbols of the set in progress and judges the whole buffer.
  logic [8:0] mb[NL][16];
  int         mn[NL];
  bit         mact[NL];
  bit         eTsV[NL], eSkp[NL], eEios[NL], eFts[NL], eErr[NL];
  logic [1:0] eType[NL];
  logic [8:0] eLink[NL], eLane[NL];
  logic [7:0] eNfts[NL], eRate[NL], eCtl[NL];
  logic [2:0] eSkpLen[NL];
  int         eCons[NL];

  always @(posedge Clk) begin : model
    int kind, n, len;
    logic [8:0] c, s1;
    bit ok, same;
    logic [1:0] nt;
    logic [8:0] nl, nla;
    for (int ln = 0; ln < NL; ln++) begin
      if (!notReset) begin
        mact[ln] = 0; mn[ln] = 0; eTsV[ln] = 0; eSkp[ln] = 0; eEios[ln] = 0; eFts[ln] = 0;
        eErr[ln] = 0; eType[ln] = 0; eLink[ln] = 0; eLane[ln] = 0; eNfts[ln] = 0;
        eRate[ln] = 0; eCtl[ln] = 0; eSkpLen[ln] = 0; eCons[ln] = 0;
      end else begin
        eTsV[ln] = 0; eSkp[ln] = 0; eEios[ln] = 0; eFts[ln] = 0; eErr[ln] = 0;
        kind = K_PEND; len = 0;
        if (!Synced[ln]) begin
          mact[ln] = 0; mn[ln] = 0;
        end else if (RxValid[ln]) begin
          c = {RxCtrl[ln], RxByte[8*ln +: 8]};
          if (!mact[ln]) begin
            if (c == COMS) begin mact[ln] = 1; mb[ln][0] = c; mn[ln] = 1; end
          end else begin
            mb[ln][mn[ln]] = c; mn[ln]++; n = mn[ln]; s1 = mb[ln][1];
            if (c == COMS) begin
              ok = (n > 2);
              for (int j = 1; j < n - 1; j++) if (mb[ln][j] != SKPS) ok = 0;
              if (n == 2) kind = K_NONE;
              else if (ok) begin kind = K_SKP; len = n - 2; end
              else kind = K_ERR;
            end else if (s1 == SKPS) begin
              if (c != SKPS) begin kind = K_SKP; len = n - 2; end
              else if (n - 1 == 6) kind = K_ERR;
            end else if (s1 == IDLS || s1 == FTSS) begin
              if (c != s1) kind = K_ERR;
              else if (n == 4) kind = (s1 == IDLS) ? K_EIOS : K_FTS;
            end else if (!s1[8] || s1 == PADS) begin
              if (n > 2) begin
                if (n - 1 == 2)      ok = !c[8] || c == PADS;
                else if (n - 1 <= 5) ok = !c[8];
                else if (n - 1 == 6) ok = (c == 9'h04A || c == 9'h045);
                else                 ok = (c == mb[ln][6]);
                if (!ok) kind = K_ERR;
                else if (n == 16) kind = K_TS;
              end
            end else begin
              kind = K_ERR;
            end
            if (kind != K_PEND) begin
              if (c == COMS) begin mb[ln][0] = c; mn[ln] = 1; end
              else begin mact[ln] = 0; mn[ln] = 0; end
            end
          end
        end
        same = 0;
        if (kind == K_TS) begin
          nt  = (mb[ln][6] == 9'h045) ? 2'b10 : 2'b01;
          nl  = {mb[ln][1] == PADS, mb[ln][1][7:0]};
          nla = {mb[ln][2] == PADS, mb[ln][2][7:0]};
          same = (nt == eType[ln]) && (nl == eLink[ln]) && (nla == eLane[ln]) &&
                 (mb[ln][3][7:0] == eNfts[ln]) && (mb[ln][4][7:0] == eRate[ln]) &&
                 (mb[ln][5][7:0] == eCtl[ln]);
          eTsV[ln] = 1; eType[ln] = nt; eLink[ln] = nl; eLane[ln] = nla;
          eNfts[ln] = mb[ln][3][7:0]; eRate[ln] = mb[ln][4][7:0]; eCtl[ln] = mb[ln][5][7:0];
        end
        if (kind == K_SKP)  begin eSkp[ln] = 1; eSkpLen[ln] = 3'(len); end
        if (kind == K_EIOS) eEios[ln] = 1;
        if (kind == K_FTS)  eFts[ln] = 1;
        if (kind == K_ERR)  eErr[ln] = 1;
        if (ClrCounts || !Synced[ln]) eCons[ln] = 0;
        else if (kind == K_TS) eCons[ln] = !same ? 1 : ((eCons[ln] >= CMAX) ? CMAX : eCons[ln] + 1);
      end
    end
  end

  always @(negedge Clk) begin : compare
    logic [63:0] act, exp;
    if (running) begin
      for (int ln = 0; ln < NL; ln++) begin
        act = {TsValid[ln], TsType[2*ln +: 2], TsLinkNum[9*ln +: 9], TsLaneNum[9*ln +: 9],
               TsNFts[8*ln +: 8], TsRate[8*ln +: 8], TsTrnCtl[8*ln +: 8], TsConsec[4*ln +: 4],
               TsMatched[ln], SkpDet[ln], SkpLen[3*ln +: 3], EiosDet[ln], FtsDet[ln], OsError[ln]};
        exp = {eTsV[ln], eType[ln], eLink[ln], eLane[ln], eNfts[ln], eRate[ln], eCtl[ln],
               4'(eCons[ln]), eCons[ln] >= 8, eSkp[ln], eSkpLen[ln], eEios[ln], eFts[ln], eErr[ln]};
        check($sformatf("lane%0d outputs", ln), act, exp);
        if (TsValid[ln]) tsSeen[ln]++;
        if (SkpDet[ln]) begin skpSeen[ln]++; lastSkpLen[ln] = int'(SkpLen[3*ln +: 3]); end
        if (EiosDet[ln]) eiosSeen[ln]++;
        if (FtsDet[ln]) ftsSeen[ln]++;
        if (OsError[ln]) errSeen[ln]++;
      end
    end
  end

  task automatic put(input int ln, input logic [8:0] s);
    RxValid = '0;
    RxValid[ln] = 1'b1;
    RxCtrl[ln] = s[8];
    RxByte[8*ln +: 8] = s[7:0];
    @(negedge Clk);
    RxValid = '0;
  endtask

  task automatic idle(input int n);
    RxValid = '0;
    repeat (n) @(negedge Clk);
  endtask

  task automatic sendTs(input int ln, input bit ts2, input logic [8:0] link, input logic [8:0] lane,
                        input logic [7:0] nfts, input logic [7:0] rate, input logic [7:0] ctl,
                        input int upto, input int gap, input int badPos, input logic [8:0] badSym,
                        input bit clrLast);
    logic [8:0] s[16];
    s[0] = COMS;
    s[1] = link[8] ? PADS : {1'b0, link[7:0]};
    s[2] = lane[8] ? PADS : {1'b0, lane[7:0]};
    s[3] = {1'b0, nfts}; s[4] = {1'b0, rate}; s[5] = {1'b0, ctl};
    for (int j = 6; j < 16; j++) s[j] = ts2 ? 9'h045 : 9'h04A;
    if (badPos > 0) s[badPos] = badSym;
    for (int j = 0; j < upto; j++) begin
      if (clrLast && j == 15) ClrCounts = 1'b1;
      put(ln, s[j]);
      ClrCounts = 1'b0;
      if (gap > 0 && j < upto - 1) idle(gap);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    notReset = 1'b0; Synced = '1; RxValid = '0; RxCtrl = '0; RxByte = '0; ClrCounts = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset TsValid", 64'(TsValid), 64'h0);
    check("reset TsConsec", 64'(TsConsec), 64'h0);
    notReset = 1'b1;
    idle(2);

    // Lane 0: eight identical TS1s reach the match threshold on the eighth.
    for (int n = 1; n <= 8; n++) begin
      sendTs(0, 0, 9'h001, 9'h000, 8'h20, 8'h02, 8'h00, 16, 0, 0, 9'h0, 0);
      idle(2);
      check($sformatf("l0 consec after TS %0d", n), 64'(TsConsec[3:0]), 64'(n));
      check($sformatf("l0 matched after TS %0d", n), 64'(TsMatched[0]), 64'(n >= 8));
    end
    check("l0 type", 64'(TsType[1:0]), 64'h1);
    check("l0 link", 64'(TsLinkNum[8:0]), 64'h001);
    check("l0 nfts", 64'(TsNFts[7:0]), 64'h20);

    // Lane 1: TS2 with PAD link/lane, repeat, then a differing N_FTS.
    sendTs(1, 1, 9'h1F7, 9'h1F7, 8'h10, 8'h02, 8'h00, 16, 0, 0, 9'h0, 0);
    idle(2);
    check("l1 link pad", 64'(TsLinkNum[17:9]), 64'h1F7);
    check("l1 lane pad", 64'(TsLaneNum[17:9]), 64'h1F7);
    check("l1 type", 64'(TsType[3:2]), 64'h2);
    check("l1 consec first", 64'(TsConsec[7:4]), 64'h1);
    sendTs(1, 1, 9'h1F7, 9'h1F7, 8'h10, 8'h02, 8'h00, 16, 0, 0, 9'h0, 0);
    idle(2);
    check("l1 consec repeat", 64'(TsConsec[7:4]), 64'h2);
    sendTs(1, 1, 9'h1F7, 9'h1F7, 8'h11, 8'h02, 8'h00, 16, 0, 0, 9'h0, 0);
    idle(2);
    check("l1 consec new nfts", 64'(TsConsec[7:4]), 64'h1);
    check("l1 nfts", 64'(TsNFts[15:8]), 64'h11);

    // Lane 2: COM + 3 SKP closed by the COM of a TS1; then COM + 6 SKP.
    put(2, COMS);
    repeat (3) put(2, SKPS);
    sendTs(2, 0, 9'h001, 9'h001, 8'h20, 8'h02, 8'h00, 16, 0, 0, 9'h0, 0);
    idle(2);
    check("l2 skp count", 64'(skpSeen[2]), 64'd1);
    check("l2 skp len", 64'(lastSkpLen[2]), 64'd3);
    check("l2 ts after skp", 64'(tsSeen[2]), 64'd1);
    put(2, COMS);
    repeat (6) put(2, SKPS);
    put(2, 9'h000);
    idle(2);
    check("l2 six skp error", 64'(errSeen[2]), 64'd1);
    check("l2 six skp no det", 64'(skpSeen[2]), 64'd1);

    // Lane 3: EIOS, FTS, mixed IDL/FTS.
    put(3, COMS); repeat (3) put(3, IDLS);
    put(3, COMS); repeat (3) put(3, FTSS);
    put(3, COMS); put(3, IDLS); put(3, FTSS);
    idle(2);
    check("l3 eios", 64'(eiosSeen[3]), 64'd1);
    check("l3 fts", 64'(ftsSeen[3]), 64'd1);
    check("l3 mixed error", 64'(errSeen[3]), 64'd1);

    // Lane 0: TS2 identifier at symbol 10 of a TS1, then a COM at symbol 8.
    sendTs(0, 0, 9'h001, 9'h000, 8'h20, 8'h02, 8'h00, 16, 0, 10, 9'h045, 0);
    idle(2);
    check("l0 bad id error", 64'(errSeen[0]), 64'd1);
    check("l0 bad id no ts", 64'(tsSeen[0]), 64'd8);
    check("l0 bad id consec", 64'(TsConsec[3:0]), 64'd8);
    sendTs(0, 0, 9'h001, 9'h000, 8'h20, 8'h02, 8'h00, 8, 0, 0, 9'h0, 0);
    sendTs(0, 0, 9'h001, 9'h000, 8'h20, 8'h02, 8'h00, 16, 0, 0, 9'h0, 0);
    idle(2);
    check("l0 com mid error", 64'(errSeen[0]), 64'd2);
    check("l0 com mid ts", 64'(tsSeen[0]), 64'd9);
    check("l0 com mid consec", 64'(TsConsec[3:0]), 64'd9);

    // Lane 1: gaps in RxValid, then Synced dropped mid-TS.
    sendTs(1, 1, 9'h1F7, 9'h1F7, 8'h11, 8'h02, 8'h00, 16, 2, 0, 9'h0, 0);
    idle(2);
    check("l1 gap ts", 64'(tsSeen[1]), 64'd4);
    check("l1 gap consec", 64'(TsConsec[7:4]), 64'h2);
    sendTs(1, 1, 9'h1F7, 9'h1F7, 8'h11, 8'h02, 8'h00, 6, 0, 0, 9'h0, 0);
    Synced[1] = 1'b0;
    idle(1);
    Synced[1] = 1'b1;
    repeat (10) put(1, 9'h045);
    idle(2);
    check("l1 unsync no ts", 64'(tsSeen[1]), 64'd4);
    check("l1 unsync consec", 64'(TsConsec[7:4]), 64'h0);
    check("l1 unsync link held", 64'(TsLinkNum[17:9]), 64'h1F7);

    // Lane 0: ClrCounts on the same edge as the final TS symbol.
    sendTs(0, 0, 9'h001, 9'h000, 8'h20, 8'h02, 8'h00, 16, 0, 0, 9'h0, 1);
    idle(2);
    check("l0 clr ts", 64'(tsSeen[0]), 64'd10);
    check("l0 clr consec", 64'(TsConsec[3:0]), 64'h0);
    sendTs(0, 0, 9'h001, 9'h000, 8'h20, 8'h02, 8'h00, 16, 0, 0, 9'h0, 0);
    idle(2);
    check("l0 after clr consec", 64'(TsConsec[3:0]), 64'h1);

    // Reset in the middle of a TS on lane 2.
    sendTs(2, 0, 9'h001, 9'h001, 8'h20, 8'h02, 8'h00, 5, 0, 0, 9'h0, 0);
    #1 notReset = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    notReset = 1'b1;
    repeat (11) put(2, 9'h04A);
    idle(2);
    check("l2 reset no ts", 64'(tsSeen[2]), 64'd1);
    check("reset clears type", 64'(TsType[1:0]), 64'h0);
    check("reset clears link", 64'(TsLinkNum[17:9]), 64'h0);

    running = 1'b0;
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
